// File: rtl/regfile_writeback.sv
// regfile_writeback: consumer end of the ALU result bus.
// Runs an 8-phase instruction cycle per start pulse, feeds the ALU its operand
// and writes ALU results back into the GPRs, EIP and a small stack RAM.
// Optional feature macro: STACK_GUARD_EN (push-when-full / pop-when-empty guard).
module regfile_writeback #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned SP_W        = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] ope,
    input  logic [31:0] alu_result_bus,
    output logic [31:0] registor_in,
    output logic        alu_en_a,
    output logic        alu_en_b,
    output logic        busy,
    output logic [2:0]  phase,
    output logic [31:0] eax_out,
    output logic [31:0] esp_out,
    output logic [31:0] ebp_out,
    output logic [31:0] eip_out,
    output logic        stack_err
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_GPR = 8;
    localparam int unsigned PH_W    = 3;
    localparam int unsigned OPQ_W   = 16;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_POP_EBP  = 8'h5d;
    localparam logic [7:0] OP_MOV_RM_R = 8'h89;
    localparam logic [7:0] OP_MOV_EAX  = 8'hb8;
    localparam logic [7:0] OP_RET      = 8'hc3;
    localparam logic [7:0] OP_CALL     = 8'he8;

    localparam logic [2:0] IDX_EAX = 3'd0;
    localparam logic [2:0] IDX_ESP = 3'd4;
    localparam logic [2:0] IDX_EBP = 3'd5;

    localparam logic [PH_W-1:0] PH_A_EN = PH_W'(4);
    localparam logic [PH_W-1:0] PH_A_WB = PH_W'(5);
    localparam logic [PH_W-1:0] PH_B_EN = PH_W'(6);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(7);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [OPQ_W-1:0]   ope_q, ope_d;
    logic [DATA_W-1:0]  gpr_q [NUM_GPR];
    logic [DATA_W-1:0]  eip_q;
    logic [DATA_W-1:0]  stack_mem [STACK_DEPTH];

    logic [7:0]         opcode;
    logic [2:0]         modrm_reg;
    logic [2:0]         modrm_rm;
    logic               modrm_is_reg;
    logic [SP_W-1:0]    sp_idx;
    logic               wr_a;
    logic               wr_b;
    logic               suppress;
    logic               unused_ope_bits;

    assign opcode       = ope_q[15:8];
    assign modrm_is_reg = (ope_q[7:6] == 2'b11);
    assign modrm_reg    = ope_q[5:3];
    assign modrm_rm     = ope_q[2:0];
    assign sp_idx       = gpr_q[IDX_ESP][SP_W-1:0];
    assign unused_ope_bits = ^ope[15:0];

    assign busy     = (state_q == ST_BUSY);
    assign phase    = phase_q;
    assign alu_en_a = busy && (phase_q == PH_A_EN);
    assign alu_en_b = busy && (phase_q == PH_B_EN);
    assign wr_a     = busy && (phase_q == PH_A_WB);
    assign wr_b     = busy && (phase_q == PH_LAST);

    assign eax_out = gpr_q[IDX_EAX];
    assign esp_out = gpr_q[IDX_ESP];
    assign ebp_out = gpr_q[IDX_EBP];
    assign eip_out = eip_q;

    // Sequencer state, phase counter and latched instruction bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            ope_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ope_q   <= ope_d;
        end
    end

    // Next-state logic: idle waits for start, busy walks phases 0..7
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ope_d   = ope_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    phase_d = '0;
                    ope_d   = ope[31:16];
                end
            end
            ST_BUSY: begin
                if (phase_q == PH_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

`ifdef STACK_GUARD_EN
    logic suppress_q;
    logic stack_err_q;
    logic guard_hit;

    assign guard_hit = busy && (phase_q == '0) &&
                       (((opcode == OP_PUSH_EBP) &&
                         (gpr_q[IDX_ESP] == DATA_W'(STACK_DEPTH - 1))) ||
                        ((opcode == OP_POP_EBP) &&
                         (gpr_q[IDX_ESP] == '0)));

    // Evaluate the stack guard once per cycle at phase 0; error flag is sticky
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            suppress_q  <= 1'b0;
            stack_err_q <= 1'b0;
        end else if (busy && (phase_q == '0)) begin
            suppress_q  <= guard_hit;
            stack_err_q <= stack_err_q | guard_hit;
        end
    end

    assign suppress  = suppress_q;
    assign stack_err = stack_err_q;
`else
    assign suppress  = 1'b0;
    assign stack_err = 1'b0;
`endif

    // Operand mux towards the ALU, decoded from the latched instruction
    always_comb begin
        registor_in = '0;
        case (opcode)
            OP_PUSH_EBP: registor_in = (phase_q < PH_A_WB) ? gpr_q[IDX_ESP] : gpr_q[IDX_EBP];
            OP_MOV_RM_R: registor_in = gpr_q[modrm_reg];
            OP_POP_EBP:  registor_in = (phase_q < PH_A_WB) ? stack_mem[sp_idx] : gpr_q[IDX_ESP];
            default:     registor_in = '0;
        endcase
    end

    // GPR and EIP writeback at phase 5 (A) and phase 7 (B)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                gpr_q[i] <= '0;
            end
            eip_q <= '0;
        end else if (wr_a) begin
            case (opcode)
                OP_PUSH_EBP: if (!suppress) gpr_q[IDX_ESP] <= alu_result_bus;
                OP_MOV_RM_R: if (modrm_is_reg) gpr_q[modrm_rm] <= alu_result_bus;
                OP_MOV_EAX:  gpr_q[IDX_EAX] <= alu_result_bus;
                OP_POP_EBP:  if (!suppress) gpr_q[IDX_EBP] <= alu_result_bus;
                OP_RET,
                OP_CALL:     eip_q <= alu_result_bus;
                default:     ;
            endcase
        end else if (wr_b) begin
            case (opcode)
                OP_POP_EBP:  if (!suppress) gpr_q[IDX_ESP] <= alu_result_bus;
                OP_RET,
                OP_CALL:     eip_q <= alu_result_bus;
                default:     ;
            endcase
        end
    end

    // Stack RAM: push stores at phase 7 using the already-updated esp
    always_ff @(posedge clock) begin
        if (wr_b && (opcode == OP_PUSH_EBP) && !suppress) begin
            stack_mem[sp_idx] <= alu_result_bus;
        end
    end

endmodule
